// File: rtl/frame_packer_pkg.sv
// frame_packer_pkg: shared frame constants, FSM state type and the CRC-8 used by packer and receiver-side checker
package frame_packer_pkg;
  localparam int FRAME_BITS = 56;
  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hAA;
  localparam logic [7:0] CRC_POLY_DFLT = 8'h07;
  typedef enum logic {IDLE, SHIFT} state_e;
  function automatic logic [7:0] crc8_48(input logic [47:0] d, input logic [7:0] poly);
    logic [7:0] c;
    c = '0;
    for (int i = 47; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? poly : 8'h00);
    return c;
  endfunction
endpackage

// File: rtl/frame_packer_if.sv
// frame_packer_if: word input and serial bit output bus; slave = packer side, master = producer/encoder side
interface frame_packer_if;
  logic [31:0] din;
  logic din_valid;
  logic tx_bit;
  logic tx_bit_valid;
  logic tx_bit_ready;
  logic [7:0] frame_count;
  modport master(output din, din_valid, tx_bit_ready, input tx_bit, tx_bit_valid, frame_count);
  modport slave(input din, din_valid, tx_bit_ready, output tx_bit, tx_bit_valid, frame_count);
endinterface

// File: rtl/frame_packer_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO; ports clk, rst, push_i/data_i write, pop_i/data_o read, full_o/empty_o flags
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  always_comb begin
    full_o = cnt_q == CW'(DEPTH);
    empty_o = cnt_q == '0;
    data_o = mem_q[rd_q];
    do_pop = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/frame_packer.sv
// frame_packer: buffers 32-bit words and serialises each as a 56-bit SYNC/CNT/DATA/CRC frame, MSB-first
// ports: clk_sys, rst (sync, active-high); bus.din/din_valid word input (dropped when full),
//        bus.tx_bit/tx_bit_valid/tx_bit_ready serial handshake, bus.frame_count frames sent mod 256
module frame_packer import frame_packer_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DFLT,
  parameter logic [7:0] CRC_POLY = CRC_POLY_DFLT
) (
  input logic           clk_sys,
  input logic           rst,
  frame_packer_if.slave bus
);
  state_e state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [31:0] head;
  logic [47:0] hdr;
  logic full, empty, push, pop, hs, last;
  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_sys),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .data_i(bus.din),
    .data_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      bit_cnt_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    pop = state_q == IDLE && !empty;
    hs = state_q == SHIFT && bus.tx_bit_ready;
    last = hs && bit_cnt_q == 6'(FRAME_BITS - 1);
    // a full FIFO still accepts a word when the head leaves on the same edge
    push = bus.din_valid && (!full || pop);
    state_d = state_q == IDLE ? (empty ? IDLE : SHIFT) : (last ? IDLE : SHIFT);
    hdr = {SYNC_BYTE, cnt_q, head};
    sr_d = pop ? {hdr, crc8_48(hdr, CRC_POLY)} : hs ? {sr_q[FRAME_BITS-2:0], 1'b0} : sr_q;
    bit_cnt_d = pop ? 6'd0 : hs ? bit_cnt_q + 6'd1 : bit_cnt_q;
    cnt_d = last ? cnt_q + 8'd1 : cnt_q;
  end
  always_comb begin
    bus.tx_bit_valid = state_q == SHIFT;
    bus.tx_bit = sr_q[FRAME_BITS-1];
    bus.frame_count = cnt_q;
  end
endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: directed self-checking bench for frame_packer
module tb_frame_packer;
  logic clk_sys, rst;
  int checks, errors;
  logic [7:0] exp_cnt;
  logic [55:0] f;
  int waitc;
  logic gap_v;
  frame_packer_if bus();
  frame_packer #(.FIFO_DEPTH(4)) dut (.clk_sys(clk_sys), .rst(rst), .bus(bus));
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] crc_model(input logic [47:0] m);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 5; b >= 0; b--) begin
      c ^= m[b*8 +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? {c[6:0], 1'b0} ^ 8'h07 : {c[6:0], 1'b0};
    end
    return c;
  endfunction
  function automatic logic [55:0] frame_of(input logic [7:0] cnt, input logic [31:0] d);
    return {8'hAA, cnt, d, crc_model({8'hAA, cnt, d})};
  endfunction
  task automatic write_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      bus.din = base + i;
      bus.din_valid = 1'b1;
    end
    @(negedge clk_sys);
    bus.din_valid = 1'b0;
  endtask
  // bp > 0 drops ready on every bp-th cycle; returns the frame, idle cycles seen before it, and valid just after it
  task automatic recv_frame(input int bp, output logic [55:0] fr, output int wc, output logic post_v);
    int n, t;
    logic held, hb;
    n = 0; t = 0; held = 1'b0; hb = 1'b0; fr = '0; wc = 0;
    while (n < 56 && t < 2000) begin
      @(negedge clk_sys);
      t++;
      if (held) check("hold", {62'd0, bus.tx_bit_valid, bus.tx_bit}, {62'd0, 1'b1, hb});
      bus.tx_bit_ready = (bp == 0) || (t % bp != 0);
      held = bus.tx_bit_valid && !bus.tx_bit_ready;
      hb = bus.tx_bit;
      if (!bus.tx_bit_valid && n == 0) wc++;
      if (bus.tx_bit_valid && bus.tx_bit_ready) begin
        fr = {fr[54:0], bus.tx_bit};
        n++;
      end
    end
    if (n < 56) check("timeout", 64'(n), 64'd56);
    @(negedge clk_sys);
    post_v = bus.tx_bit_valid;
  endtask
  initial begin
    int n, t, vc;
    checks = 0; errors = 0;
    rst = 1'b1;
    bus.din = '0; bus.din_valid = 1'b0; bus.tx_bit_ready = 1'b0;
    repeat (5) @(negedge clk_sys);
    rst = 1'b0;
    check("rst_cnt", 64'(bus.frame_count), 64'h0);
    check("rst_valid", 64'(bus.tx_bit_valid), 64'h0);
    check("rst_bit", 64'(bus.tx_bit), 64'h0);
    vc = 0;
    repeat (10) begin @(negedge clk_sys); vc += int'(bus.tx_bit_valid); end
    check("idle_empty", 64'(vc), 64'h0);
    exp_cnt = 8'h00;
    // single frame with latency
    write_words(32'h0, 1);
    check("lat_e0", 64'(bus.tx_bit_valid), 64'h0);
    @(negedge clk_sys);
    check("lat_e1_v", 64'(bus.tx_bit_valid), 64'h1);
    check("lat_e1_b", 64'(bus.tx_bit), 64'h1);
    recv_frame(0, f, waitc, gap_v);
    check("single", 64'(f), 64'h00AA0000000000CA);
    check("single_crc", 64'(frame_of(8'h00, 32'h0)), 64'h00AA0000000000CA);
    check("single_cnt", 64'(bus.frame_count), 64'h1);
    check("single_gap", 64'(gap_v), 64'h0);
    exp_cnt = 8'h01;
    // sequential frames
    bus.tx_bit_ready = 1'b0;
    write_words(32'h11110000, 5);
    for (int i = 0; i < 5; i++) begin
      recv_frame(0, f, waitc, gap_v);
      check("seq_frame", 64'(f), 64'(frame_of(exp_cnt, 32'h11110000 + i)));
      check("seq_cnt_field", 64'(f[47:40]), 64'(8'(i + 1)));
      check("seq_wait", 64'(waitc), 64'h0);
      check("seq_gap", 64'(gap_v), 64'h0);
      exp_cnt++;
      check("seq_fcount", 64'(bus.frame_count), 64'(exp_cnt));
    end
    // backpressure
    bus.tx_bit_ready = 1'b0;
    write_words(32'h55555555, 1);
    recv_frame(7, f, waitc, gap_v);
    check("bp_frame", 64'(f), 64'(frame_of(exp_cnt, 32'h55555555)));
    check("bp_gap", 64'(gap_v), 64'h0);
    exp_cnt++;
    check("bp_fcount", 64'(bus.frame_count), 64'(exp_cnt));
    // overflow: shifter holds one frame, FIFO takes 4, last 2 words dropped
    bus.tx_bit_ready = 1'b0;
    write_words(32'hDEADBEEF, 1);
    @(negedge clk_sys);
    write_words(32'hC0FFEE00, 6);
    recv_frame(0, f, waitc, gap_v);
    check("ovf_pre", 64'(f), 64'(frame_of(exp_cnt, 32'hDEADBEEF)));
    exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      recv_frame(0, f, waitc, gap_v);
      check("ovf_frame", 64'(f), 64'(frame_of(exp_cnt, 32'hC0FFEE00 + i)));
      check("ovf_wait", 64'(waitc), 64'h0);
      check("ovf_gap", 64'(gap_v), 64'h0);
      exp_cnt++;
    end
    vc = 0;
    repeat (20) begin @(negedge clk_sys); vc += int'(bus.tx_bit_valid); end
    check("ovf_dropped", 64'(vc), 64'h0);
    check("ovf_fcount", 64'(bus.frame_count), 64'(exp_cnt));
    // counter wrap over 256 frames
    for (int i = 0; i < 256; i++) begin
      write_words(32'hA5000000 + i, 1);
      recv_frame(0, f, waitc, gap_v);
      check("wrap_cnt_field", 64'(f[47:40]), 64'(exp_cnt));
      check("wrap_frame", 64'(f), 64'(frame_of(exp_cnt, 32'hA5000000 + i)));
      exp_cnt++;
    end
    check("wrap_fcount", 64'(bus.frame_count), 64'(exp_cnt));
    // mid-frame reset, second word waiting in FIFO must be flushed
    bus.tx_bit_ready = 1'b0;
    write_words(32'h12345678, 2);
    n = 0; t = 0;
    while (n < 20 && t < 200) begin
      @(negedge clk_sys);
      t++;
      bus.tx_bit_ready = 1'b1;
      if (bus.tx_bit_valid) n++;
    end
    check("mid_bits", 64'(n), 64'd20);
    rst = 1'b1;
    @(negedge clk_sys);
    rst = 1'b0;
    check("mid_valid", 64'(bus.tx_bit_valid), 64'h0);
    check("mid_bit", 64'(bus.tx_bit), 64'h0);
    check("mid_fcount", 64'(bus.frame_count), 64'h0);
    vc = 0;
    repeat (10) begin @(negedge clk_sys); vc += int'(bus.tx_bit_valid); end
    check("mid_flushed", 64'(vc), 64'h0);
    write_words(32'hFEEDF00D, 1);
    recv_frame(0, f, waitc, gap_v);
    check("post_rst_cnt", 64'(f[47:40]), 64'h0);
    check("post_rst_frame", 64'(f), 64'(frame_of(8'h00, 32'hFEEDF00D)));
    check("post_rst_fcount", 64'(bus.frame_count), 64'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
